// File: rtl/work_shifter.sv
// Serialises WORK_BITS-wide work packets MSB-first onto din/shift, with a
// one-entry pending slot so the next packet can be queued while one shifts.
module work_shifter #(
  parameter int WORK_BITS  = 352,
  parameter int GAP_CYCLES = 4
) (
  input  logic                 hash_clk,
  input  logic                 reset_n,
  input  logic [WORK_BITS-1:0] work_data,
  input  logic                 work_valid,
  output logic                 work_ready,
  output logic                 din,
  output logic                 shift,
  output logic                 loaded,
  output logic                 busy,
  output logic [1:0]           o_dbg_state
);

  localparam int CW = $clog2(WORK_BITS + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  state_t                 r_state;
  logic [WORK_BITS-1:0]   r_sreg;
  logic [CW-1:0]          r_bit_cnt;
  logic [3:0]             r_gap_cnt;
  logic [WORK_BITS-1:0]   r_pend;
  logic                   r_pend_full;
  logic                   r_shift;
  logic                   r_din;
  logic                   r_loaded;
  logic                   r_busy;

  state_t                 w_state_nxt;
  logic [WORK_BITS-1:0]   w_sreg_nxt;
  logic [CW-1:0]          w_bit_cnt_nxt;
  logic [3:0]             w_gap_cnt_nxt;
  logic                   w_pend_full_nxt;
  logic                   w_loaded_nxt;
  logic                   w_load;
  logic                   w_accept;

  // Handshake: a beat transfers on a rising edge where work_valid && work_ready;
  // work_ready depends only on the pending flag, never on work_valid.
  assign w_accept = work_valid & ~r_pend_full;

  always_comb begin
    w_state_nxt     = r_state;
    w_sreg_nxt      = r_sreg;
    w_bit_cnt_nxt   = r_bit_cnt;
    w_gap_cnt_nxt   = r_gap_cnt;
    w_pend_full_nxt = r_pend_full;
    w_loaded_nxt    = 1'b0;
    w_load          = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (r_pend_full) w_load = 1'b1;
      end
      S_SHIFT: begin
        w_sreg_nxt    = {r_sreg[WORK_BITS-2:0], 1'b0};
        w_bit_cnt_nxt = r_bit_cnt - CW'(1);
        if (r_bit_cnt == CW'(1)) begin
          w_state_nxt   = S_GAP;
          w_gap_cnt_nxt = 4'd0;
          w_loaded_nxt  = 1'b1;
        end
      end
      S_GAP: begin
        if (r_gap_cnt == 4'(GAP_CYCLES - 1)) begin
          w_gap_cnt_nxt = 4'd0;
          if (r_pend_full) w_load = 1'b1;
          else             w_state_nxt = S_IDLE;
        end else begin
          w_gap_cnt_nxt = r_gap_cnt + 4'd1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    // A load needs pending_full set, so it never coincides with an accept.
    if (w_load) begin
      w_state_nxt     = S_SHIFT;
      w_sreg_nxt      = r_pend;
      w_bit_cnt_nxt   = CW'(WORK_BITS);
      w_pend_full_nxt = 1'b0;
    end
    if (w_accept) w_pend_full_nxt = 1'b1;
  end

  always_ff @(posedge hash_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_sreg      <= '0;
      r_bit_cnt   <= '0;
      r_gap_cnt   <= '0;
      r_pend      <= '0;
      r_pend_full <= 1'b0;
      r_shift     <= 1'b0;
      r_din       <= 1'b0;
      r_loaded    <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_sreg      <= w_sreg_nxt;
      r_bit_cnt   <= w_bit_cnt_nxt;
      r_gap_cnt   <= w_gap_cnt_nxt;
      r_pend_full <= w_pend_full_nxt;
      if (w_accept) r_pend <= work_data;
      // Outputs are registered from next-state values so they line up with the state.
      r_shift     <= (w_state_nxt == S_SHIFT);
      r_din       <= (w_state_nxt == S_SHIFT) & w_sreg_nxt[WORK_BITS-1];
      r_loaded    <= w_loaded_nxt;
      r_busy      <= (w_state_nxt != S_IDLE) | w_pend_full_nxt;
    end
  end

  assign work_ready  = ~r_pend_full;
  assign din         = r_din;
  assign shift       = r_shift;
  assign loaded      = r_loaded;
  assign busy        = r_busy;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_work_shifter.sv
// Directed bench for work_shifter: a 352-bit/gap-4 instance and an 8-bit/gap-2
// instance sharing clock and reset.
module tb_work_shifter;

  logic         clk;
  logic         rst_n;

  logic [351:0] a_data;
  logic         a_valid, a_ready, a_din, a_shift, a_loaded, a_busy;
  logic [1:0]   a_state;

  logic [7:0]   b_data;
  logic         b_valid, b_ready, b_din, b_shift, b_loaded, b_busy;
  logic [1:0]   b_state;

  int checks = 0;
  int errors = 0;
  int a_loaded_n = 0;
  int b_loaded_n = 0;

  localparam logic [351:0] P1 = {1'b1, 351'b0};
  localparam logic [351:0] P2 = {11{32'hDEADBEEF}};
  localparam logic [351:0] P3 = {44{8'hAA}};
  localparam logic [351:0] P4 = {8'hF0, 344'b0};

  work_shifter #(.WORK_BITS(352), .GAP_CYCLES(4)) dut_a (
    .hash_clk(clk), .reset_n(rst_n), .work_data(a_data), .work_valid(a_valid),
    .work_ready(a_ready), .din(a_din), .shift(a_shift), .loaded(a_loaded),
    .busy(a_busy), .o_dbg_state(a_state)
  );

  work_shifter #(.WORK_BITS(8), .GAP_CYCLES(2)) dut_b (
    .hash_clk(clk), .reset_n(rst_n), .work_data(b_data), .work_valid(b_valid),
    .work_ready(b_ready), .din(b_din), .shift(b_shift), .loaded(b_loaded),
    .busy(b_busy), .o_dbg_state(b_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (a_loaded) a_loaded_n++;
    if (b_loaded) b_loaded_n++;
  end

  initial begin
    #1ms;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  // driver / checker tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [351:0] obs, input logic [351:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_rise_a();
    int k = 0;
    while (!a_shift && k < 20) begin step(); a_valid = 1'b0; k++; end
    check("a_shift_rise", a_shift, 1'b1);
  endtask

  task automatic collect_a(output logic [351:0] d, output int n);
    d = '0; n = 0;
    while (a_shift && n < 400) begin
      d = {d[350:0], a_din}; n++;
      step(); a_valid = 1'b0;
    end
  endtask

  task automatic wait_rise_b();
    int k = 0;
    while (!b_shift && k < 20) begin step(); b_valid = 1'b0; k++; end
    check("b_shift_rise", b_shift, 1'b1);
  endtask

  task automatic collect_b(output logic [7:0] d, output int n);
    d = '0; n = 0;
    while (b_shift && n < 40) begin
      d = {d[6:0], b_din}; n++;
      step(); b_valid = 1'b0;
    end
  endtask

  task automatic wait_idle_a();
    int k = 0;
    while (a_busy && k < 50) begin step(); k++; end
    check("a_idle", a_busy, 1'b0);
  endtask

  initial begin
    logic [351:0] d;
    logic [7:0]   db;
    int n, k, l0;
    logic ready_seen;

    rst_n = 1'b0; a_valid = 1'b0; a_data = '0; b_valid = 1'b0; b_data = '0;
    repeat (3) step();
    check("rst_shift", a_shift, 1'b0);
    check("rst_din", a_din, 1'b0);
    check("rst_loaded", a_loaded, 1'b0);
    check("rst_busy", a_busy, 1'b0);
    check("rst_ready", a_ready, 1'b1);
    check("rst_state", a_state, 2'd0);
    rst_n = 1'b1;
    repeat (2) step();

    // single packet, MSB only
    l0 = a_loaded_n;
    a_valid = 1'b1; a_data = P1;
    step(); a_valid = 1'b0;
    check("s1_shift_c1", a_shift, 1'b0);
    check("s1_ready_c1", a_ready, 1'b0);
    check("s1_busy_c1", a_busy, 1'b1);
    step();
    check("s1_shift_c2", a_shift, 1'b1);
    check("s1_din_first", a_din, 1'b1);
    collect_a(d, n);
    check("s1_len", n, 352);
    check("s1_data", d, P1);
    check("s1_loaded_g1", a_loaded, 1'b1);
    // busy stays high on GAP_CYCLES cycles starting with the loaded cycle
    k = 0;
    while (a_busy && k < 50) begin k++; step(); end
    check("s1_busy_after_loaded", k, 4);
    check("s1_loaded_pulses", a_loaded_n - l0, 1);
    step();

    // back-to-back: second beat at shift cycle 10
    l0 = a_loaded_n;
    a_valid = 1'b1; a_data = P1;
    wait_rise_a();
    repeat (9) step();
    check("s2_ready_c10", a_ready, 1'b1);
    a_valid = 1'b1; a_data = P2;
    step(); a_valid = 1'b0;
    check("s2_ready_held", a_ready, 1'b0);
    while (a_shift) step();
    k = 0; ready_seen = 1'b0;
    while (!a_shift && k < 50) begin
      if (a_ready) ready_seen = 1'b1;
      k++; step();
    end
    check("s2_gap", k, 4);
    check("s2_ready_low_gap", ready_seen, 1'b0);
    check("s2_ready_after_xfer", a_ready, 1'b1);
    collect_a(d, n);
    check("s2_len_b", n, 352);
    check("s2_data_b", d, P2);
    wait_idle_a();
    check("s2_loaded_pulses", a_loaded_n - l0, 2);

    // backpressure: third beat held while the slot is full
    a_valid = 1'b1; a_data = P1;
    wait_rise_a();
    a_valid = 1'b1; a_data = P2;
    step();
    a_valid = 1'b1; a_data = P3;
    k = 0;
    while (!a_ready && k < 1000) begin step(); k++; end
    check("s3_ready_rise_with_shift", a_shift, 1'b1);
    collect_a(d, n);
    check("s3_data_b", d, P2);
    check("s3_ready_low_c_pending", a_ready, 1'b0);
    k = 0;
    while (!a_shift && k < 50) begin k++; step(); end
    check("s3_gap", k, 4);
    collect_a(d, n);
    check("s3_len_c", n, 352);
    check("s3_data_c", d, P3);
    wait_idle_a();

    // reset at shift cycle 100
    a_valid = 1'b1; a_data = P2;
    wait_rise_a();
    repeat (99) step();
    check("s4_shift_c100", a_shift, 1'b1);
    l0 = a_loaded_n;
    #2 rst_n = 1'b0;
    #1;
    check("s4_rst_shift", a_shift, 1'b0);
    check("s4_rst_din", a_din, 1'b0);
    check("s4_rst_busy", a_busy, 1'b0);
    check("s4_rst_ready", a_ready, 1'b1);
    check("s4_rst_state", a_state, 2'd0);
    repeat (2) step();
    rst_n = 1'b1;
    repeat (10) step();
    check("s4_no_loaded", a_loaded_n - l0, 0);
    check("s4_quiet_shift", a_shift, 1'b0);

    // bit order after reset: F0 in the top byte
    a_valid = 1'b1; a_data = P4;
    wait_rise_a();
    collect_a(d, n);
    check("s5_len", n, 352);
    check("s5_first8", d[351:344], 8'b1111_0000);
    check("s5_rest_zero", d[343:0], 344'b0);
    wait_idle_a();

    // small instance: 8 bits, gap 2
    l0 = b_loaded_n;
    b_valid = 1'b1; b_data = 8'hA5;
    wait_rise_b();
    b_valid = 1'b1; b_data = 8'h3C;
    collect_b(db, n);
    check("s6_len1", n, 8);
    check("s6_data1", db, 8'hA5);
    k = 0;
    while (!b_shift && k < 50) begin k++; step(); end
    check("s6_gap", k, 2);
    collect_b(db, n);
    check("s6_len2", n, 8);
    check("s6_data2", db, 8'h3C);
    repeat (5) step();
    check("s6_loaded_pulses", b_loaded_n - l0, 2);
    check("s6_idle", b_busy, 1'b0);

    // report
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
